// File: rtl/code_decoder_fifo_if.sv
// Handshake bundle for code_decoder_fifo: encoded-code input side, one-hot output side,
// and the sticky-mask / occupancy status signals.
interface code_decoder_fifo_if #(
    parameter int CODE_W = 3,
    parameter int DEPTH  = 4
);
    localparam int OUT_W = 1 << CODE_W;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic              in_valid;
    logic              in_ready;
    logic [CODE_W-1:0] in_code;
    logic              in_none;
    logic              out_valid;
    logic              out_ready;
    logic [OUT_W-1:0]  out_onehot;
    logic              seen_clr;
    logic [OUT_W-1:0]  seen_mask;
    logic [CNT_W-1:0]  count;

    // The decoder block itself is the slave; whoever drives codes and consumes strobes is the master.
    modport slave (
        input  in_valid, in_code, in_none, out_ready, seen_clr,
        output in_ready, out_valid, out_onehot, seen_mask, count
    );

    modport master (
        output in_valid, in_code, in_none, out_ready, seen_clr,
        input  in_ready, out_valid, out_onehot, seen_mask, count
    );
endinterface

// File: rtl/code_decoder_fifo.sv
// Buffers encoded line indices in a small FIFO and presents the head as a one-hot vector,
// keeping a sticky OR of every line delivered since reset or the last clear.
module code_decoder_fifo #(
    parameter int CODE_W = 3,
    parameter int DEPTH  = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    code_decoder_fifo_if.slave   bus
);
    localparam int OUT_W = 1 << CODE_W;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [CODE_W:0]    mem_q [DEPTH];
    logic [PTR_W-1:0]   wrPtr_q, wrPtr_d;
    logic [PTR_W-1:0]   rdPtr_q, rdPtr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [OUT_W-1:0]   seenMask_q, seenMask_d;
    logic [OUT_W-1:0]   headOnehot;
    logic [CODE_W:0]    headEntry;
    logic               inReady;
    logic               outValid;
    logic               push;
    logic               pop;

    // Full is judged on the registered count alone, so a same-cycle pop never frees a slot for a push.
    always_comb begin
        inReady  = rst_n && (count_q < CNT_W'(DEPTH));
        outValid = (count_q != '0);
        push     = bus.in_valid && inReady;
        pop      = outValid && bus.out_ready;
    end

    // The none flag is tested before the code is used, so an undefined code never reaches the output.
    always_comb begin
        headEntry  = mem_q[rdPtr_q];
        headOnehot = '0;
        if (outValid && !headEntry[CODE_W]) begin
            headOnehot[headEntry[CODE_W-1:0]] = 1'b1;
        end
    end

    always_comb begin
        wrPtr_d    = push ? wrPtr_q + 1'b1 : wrPtr_q;
        rdPtr_d    = pop  ? rdPtr_q + 1'b1 : rdPtr_q;
        count_d    = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        seenMask_d = (bus.seen_clr ? '0 : seenMask_q) | (pop ? headOnehot : '0);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wrPtr_q    <= '0;
            rdPtr_q    <= '0;
            count_q    <= '0;
            seenMask_q <= '0;
        end else begin
            wrPtr_q    <= wrPtr_d;
            rdPtr_q    <= rdPtr_d;
            count_q    <= count_d;
            seenMask_q <= seenMask_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wrPtr_q] <= {bus.in_none, bus.in_code};
        end
    end

    assign bus.in_ready   = inReady;
    assign bus.out_valid  = outValid;
    assign bus.out_onehot = headOnehot;
    assign bus.seen_mask  = seenMask_q;
    assign bus.count      = count_q;
endmodule

// File: tb/tb_code_decoder_fifo.sv
// Scoreboard bench for code_decoder_fifo: expected one-hots are queued as codes are accepted
// and compared against the FIFO head as it is delivered.
module tb_code_decoder_fifo;
    localparam int CODE_W = 3;
    localparam int DEPTH  = 4;

    logic clk;
    logic rst_n;

    code_decoder_fifo_if #(.CODE_W(CODE_W), .DEPTH(DEPTH)) bus ();

    code_decoder_fifo #(.CODE_W(CODE_W), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         checkCount = 0;
    int         passCount  = 0;
    logic [7:0] expQ[$];
    logic [7:0] modelMask  = 8'h00;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
        end
    endtask

    // Drive one cycle of inputs, check the outputs against the scoreboard, then advance the model at the edge.
    task automatic applyStimulus(input logic v, input logic [2:0] code, input logic none,
                                 input logic rdy, input logic clr, input logic rstn);
        logic       doPush;
        logic       doPop;
        logic [7:0] popped;
        bus.in_valid  = v;
        bus.in_code   = code;
        bus.in_none   = none;
        bus.out_ready = rdy;
        bus.seen_clr  = clr;
        rst_n         = rstn;
        #1;
        checkOutput("in_ready",   32'(bus.in_ready),   32'(rstn && (expQ.size() < DEPTH)));
        checkOutput("out_valid",  32'(bus.out_valid),  32'(expQ.size() != 0));
        checkOutput("out_onehot", 32'(bus.out_onehot), 32'((expQ.size() != 0) ? expQ[0] : 8'h00));
        checkOutput("count",      32'(bus.count),      32'(expQ.size()));
        checkOutput("seen_mask",  32'(bus.seen_mask),  32'(modelMask));
        doPush = v && rstn && (expQ.size() < DEPTH);
        doPop  = rdy && (expQ.size() != 0);
        popped = doPop ? expQ[0] : 8'h00;
        @(posedge clk);
        if (!rstn) begin
            expQ.delete();
            modelMask = 8'h00;
        end else begin
            if (doPop) void'(expQ.pop_front());
            modelMask = (clr ? 8'h00 : modelMask) | popped;
            if (doPush) expQ.push_back(none ? 8'h00 : (8'h01 << code));
        end
        #1;
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_code   = '0;
        bus.in_none   = 1'b0;
        bus.out_ready = 1'b0;
        bus.seen_clr  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_count",     32'(bus.count),     32'd0);
        checkOutput("rst_out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("rst_onehot",    32'(bus.out_onehot), 32'h00);
        checkOutput("rst_seen",      32'(bus.seen_mask), 32'h00);
        checkOutput("rst_in_ready",  32'(bus.in_ready),  32'd0);

        // Single push of code 5 then pop
        applyStimulus(1, 3'd5, 0, 0, 0, 1);
        checkOutput("t1_onehot", 32'(bus.out_onehot), 32'h20);
        checkOutput("t1_count",  32'(bus.count),      32'd1);
        applyStimulus(0, 3'd0, 0, 1, 0, 1);
        checkOutput("t1_seen",   32'(bus.seen_mask),  32'h20);
        checkOutput("t1_count0", 32'(bus.count),      32'd0);

        // Fill to full, drop a fifth push, drain
        applyStimulus(0, 3'd0, 0, 0, 1, 1);
        for (int i = 0; i < 4; i++) applyStimulus(1, 3'(i), 0, 0, 0, 1);
        checkOutput("t2_full_count", 32'(bus.count),    32'd4);
        checkOutput("t2_full_ready", 32'(bus.in_ready), 32'd0);
        applyStimulus(1, 3'd7, 0, 1, 0, 1);
        for (int i = 0; i < 4; i++) applyStimulus(0, 3'd0, 0, 1, 0, 1);
        checkOutput("t2_seen", 32'(bus.seen_mask), 32'h0F);

        // Back-to-back streaming of 7..0
        applyStimulus(0, 3'd0, 0, 0, 1, 1);
        for (int i = 7; i >= 0; i--) applyStimulus(1, 3'(i), 0, 1, 0, 1);
        checkOutput("t3_count", 32'(bus.count), 32'd1);
        applyStimulus(0, 3'd0, 0, 1, 0, 1);
        checkOutput("t3_seen", 32'(bus.seen_mask), 32'hFF);

        // None entry with undefined code, interleaved with wrapping traffic
        applyStimulus(0, 3'd0, 0, 0, 1, 1);
        applyStimulus(1, 3'd2, 0, 0, 0, 1);
        applyStimulus(1, 3'bxxx, 1, 1, 0, 1);
        checkOutput("t4_none_valid",  32'(bus.out_valid),  32'd1);
        checkOutput("t4_none_onehot", 32'(bus.out_onehot), 32'h00);
        applyStimulus(1, 3'd4, 0, 1, 0, 1);
        checkOutput("t4_none_seen",   32'(bus.seen_mask),  32'h04);
        applyStimulus(1, 3'd1, 0, 0, 0, 1);
        applyStimulus(1, 3'd6, 0, 1, 0, 1);
        applyStimulus(1, 3'd0, 0, 1, 0, 1);
        for (int i = 0; i < 4; i++) applyStimulus(0, 3'd0, 0, 1, 0, 1);
        checkOutput("t4_seen", 32'(bus.seen_mask), 32'h57);

        // Clear colliding with a pop of code 7
        applyStimulus(0, 3'd0, 0, 0, 1, 1);
        for (int i = 0; i < 4; i++) applyStimulus(1, 3'(i), 0, 1, 0, 1);
        applyStimulus(1, 3'd7, 0, 1, 0, 1);
        checkOutput("t5_seen_before", 32'(bus.seen_mask), 32'h0F);
        applyStimulus(0, 3'd0, 0, 1, 1, 1);
        checkOutput("t5_seen_after",  32'(bus.seen_mask), 32'h80);

        // Reset mid-stream discards stored entries
        for (int i = 0; i < 3; i++) applyStimulus(1, 3'(i + 3), 0, 0, 0, 1);
        checkOutput("t6_count3", 32'(bus.count), 32'd3);
        applyStimulus(0, 3'd0, 0, 0, 0, 0);
        checkOutput("t6_count",     32'(bus.count),     32'd0);
        checkOutput("t6_out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("t6_seen",      32'(bus.seen_mask), 32'h00);
        applyStimulus(1, 3'd2, 0, 0, 0, 1);
        applyStimulus(0, 3'd0, 0, 1, 0, 1);
        applyStimulus(0, 3'd0, 0, 0, 0, 1);

        $display("[TB] %0d/%0d checks passed", passCount, checkCount);
        $finish;
    end
endmodule

// File: doc/code_decoder_fifo.md
Name: code_decoder_fifo

Overview:
- Inverse of the 8-line priority encoder used elsewhere in the design. Accepts a stream of encoded line indices (code plus a "no line active" flag) over a valid/ready handshake.
- Buffers the codes in a small FIFO and delivers each one as a one-hot vector over a second valid/ready handshake.
- Keeps a sticky mask of every line delivered since the last clear.
- Sits downstream of the encoder, between the event-capture logic and the consumers that need per-line strobes.

Parameters:
- CODE_W, 3, width of the encoded index; output width is 2**CODE_W (8 by default).
- DEPTH, 4, FIFO entries; must be a power of two and at least 2.

Ports:
- clk  input  1  single clock; all state changes on the rising edge.
- rst_n  input  1  synchronous, active-low reset.
- in_valid  input  1  input code is valid this cycle.
- in_ready  output  1  block can accept a code this cycle.
- in_code  input  CODE_W  encoded line index.
- in_none  input  1  1 = encoder saw no active line; in_code is ignored.
- out_valid  output  1  out_onehot holds a delivered entry.
- out_ready  input  1  consumer takes the entry this cycle.
- out_onehot  output  2**CODE_W  decoded one-hot vector of the FIFO head.
- seen_clr  input  1  clear the sticky mask.
- seen_mask  output  2**CODE_W  OR of all one-hots popped since reset or last clear.
- count  output  clog2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - count=0, read and write pointers=0, out_valid=0, out_onehot=0, seen_mask=0.
  - in_ready is held 0 combinationally while rst_n=0.
  - Reset mid-operation discards all stored entries; no partial pop is reported.
- Push:
  - Occurs when in_valid && in_ready. Stores {in_none, in_code} at wptr; wptr increments mod DEPTH.
  - in_ready = rst_n && (count < DEPTH).
  - When full, in_ready=0 even if a pop happens the same cycle (no write-through on full).
- Pop:
  - Occurs when out_valid && out_ready; rptr increments mod DEPTH.
  - out_valid = (count != 0). The head is shown first-word-fall-through.
- Occupancy update per cycle:
  - push only: +1.
  - pop only: -1.
  - push and pop together: unchanged, both pointers advance.
- Latency:
  - A code accepted at edge N appears on out_valid/out_onehot after edge N (one cycle) when the FIFO was empty. There is no same-cycle bypass.
  - Throughput is one entry per cycle when both sides are ready.
- Decode:
  - If head.none=1, out_onehot = 0 (a valid entry with no line set).
  - Otherwise out_onehot = 1 << head.code.
  - When out_valid=0, out_onehot = 0.
  - Decode is purely from registered FIFO storage; there is no combinational path from in_* to out_*.
- Stability: while out_valid=1 and out_ready=0, out_onehot holds steady.
- Sticky mask update at each edge:
  - seen_mask <= (seen_clr ? 0 : seen_mask) | (pop ? out_onehot : 0).
  - Clear and pop in the same cycle leave only the popped line set.
  - A "none" entry pops without changing the mask.
- Wrap-around: pointers use exactly clog2(DEPTH) bits and wrap naturally. Full/empty are decided by count only.
- Protocol errors: in_valid asserted while in_ready=0 is ignored (no push, no state change). Any X on in_code with in_none=1 must not propagate to out_onehot.

Test Plan:
- Reset then single push: in_code=5, in_none=0 at edge 1 -> out_valid=1 after edge 1, out_onehot=8'b0010_0000, count=1. out_ready=1 at edge 2 -> count=0, seen_mask=8'b0010_0000.
- Fill to full, DEPTH=4: push codes 0,1,2,3 with out_ready=0 -> count=4, in_ready=0. A 5th in_valid with code 7 is dropped. Then pop all four -> out_onehot sequence 01,02,04,08 (hex). seen_mask=8'h0F.
- Back-to-back streaming: in_valid=out_ready=1 every cycle, codes 7,6,5,4,3,2,1,0 -> count stays 1 after the first edge, outputs 80,40,20,10,08,04,02,01 in order, seen_mask=8'hFF.
- None entry plus wrap-around: push 6 pushes/pops interleaved, including in_none=1 with in_code=3'bxxx -> the none entry pops with out_valid=1, out_onehot=0, seen_mask unchanged. Pointer wrap produces correct ordering.
- Clear collision: seen_mask=8'h0F, then in the same cycle seen_clr=1 and pop of code 7 -> seen_mask=8'h80.
- Reset mid-stream: count=3, then rst_n=0 for one edge -> count=0, out_valid=0, seen_mask=0, in_ready=0 during reset and 1 after it.
